// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: state encoding, entry points and branch target tables.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package fetch_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Program entry points, indexed by program number. Row 3 is spare.
  localparam logic [9:0] ENTRY_ADDR [4] = '{10'h000, 10'h080, 10'h100, 10'h000};

  // Absolute jump targets, indexed by TargSel.
  localparam logic [9:0] ABS_TARGET [8] = '{10'h000, 10'h000, 10'h000, 10'h040,
                                             10'h000, 10'h000, 10'h000, 10'h000};

  // Signed relative branch offsets, indexed by TargSel.
  localparam logic signed [5:0] REL_OFFSET [8] = '{6'sd0, 6'sd0, -6'sd4, 6'sd0,
                                                    6'sd0, 6'sd3, 6'sd0,  6'sd0};

  // Next program number after a completed run; wraps after the last program.
  function automatic logic [1:0] next_prog(input logic [1:0] idx, input int num_progs);
    if (int'(idx) == num_progs - 1) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/fetch_target_lut.sv
// Branch target lookup: TargSel selects an absolute target and a sign-extended relative offset.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow targ_sel every cycle.
// Ports: targ_sel (row select) -> abs_target, rel_offset_sext (both PC_W wide).
module fetch_target_lut import fetch_pkg::*; #(
  parameter int PC_W  = 10,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] targ_sel,
  output logic [PC_W-1:0]  abs_target,
  output logic [PC_W-1:0]  rel_offset_sext
);

  assign abs_target      = PC_W'(ABS_TARGET[targ_sel]);
  // Size cast of a signed operand sign-extends, so adding this to the PC
  // performs a two's-complement relative step modulo 2^PC_W.
  assign rel_offset_sext = PC_W'(REL_OFFSET[targ_sel]);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: program counter, Start/Ack run handshake, multi-program entry and branch resolution.
// Latency: branch/halt inputs affect ProgCtr/state at the next Clk edge; all outputs are registered or state decode.
// Backpressure: none; Start high during a run aborts to ARMED, Ack holds until the next Start.
// Ports: Clk, Reset (sync, active-high), Start, HaltReq, BranchAbsEn, BranchRelEn, AluZero, TargSel in;
//        ProgCtr, Running, Ack, ProgIdx, CycleCount out.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int PC_W      = 10,
  parameter int NUM_PROGS = 3,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             HaltReq,
  input  logic             BranchAbsEn,
  input  logic             BranchRelEn,
  input  logic             AluZero,
  input  logic [SEL_W-1:0] TargSel,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Ack,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount
);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       prog_idx_q, prog_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  abs_target;
  logic [PC_W-1:0]  rel_offset_sext;

  fetch_target_lut #(
    .PC_W  (PC_W),
    .SEL_W (SEL_W)
  ) u_lut (
    .targ_sel        (TargSel),
    .abs_target      (abs_target),
    .rel_offset_sext (rel_offset_sext)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_idx_d = prog_idx_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (Start) begin
          // Restart the same program.
          state_d = ST_ARMED;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (HaltReq)                       state_d = ST_DONE;
          else if (BranchAbsEn)              pc_d    = abs_target;
          else if (BranchRelEn && AluZero)   pc_d    = pc_q + rel_offset_sext;
          else                               pc_d    = pc_q + PC_W'(1);
        end
      end
      ST_DONE: begin
        if (Start) begin
          state_d    = ST_ARMED;
          prog_idx_d = next_prog(prog_idx_q, NUM_PROGS);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every edge that lands in ARMED (entry or stay) loads the entry point,
    // so ProgCtr is already correct on the first ARMED cycle and the first
    // RUN cycle fetches the entry instruction with no bubble.
    if (state_d == ST_ARMED) begin
      pc_d  = PC_W'(ENTRY_ADDR[prog_idx_d]);
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      prog_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_idx_q <= prog_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign Running    = (state_q == ST_RUN);
  assign Ack        = (state_q == ST_DONE);
  assign ProgIdx    = prog_idx_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed sequences then random stimulus vs a behavioural model.
// Latency: one expected entry per clock edge, compared one time unit after that edge.
// Backpressure: none.
module tb_fetch_sequencer;

  logic        clk;
  logic        Reset, Start, HaltReq, BranchAbsEn, BranchRelEn, AluZero;
  logic [2:0]  TargSel;
  logic [9:0]  ProgCtr;
  logic        Running, Ack;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  fetch_sequencer dut (
    .Clk         (clk),
    .Reset       (Reset),
    .Start       (Start),
    .HaltReq     (HaltReq),
    .BranchAbsEn (BranchAbsEn),
    .BranchRelEn (BranchRelEn),
    .AluZero     (AluZero),
    .TargSel     (TargSel),
    .ProgCtr     (ProgCtr),
    .Running     (Running),
    .Ack         (Ack),
    .ProgIdx     (ProgIdx),
    .CycleCount  (CycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program phase plus plain integer arithmetic.
  localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
  int m_entry [3] = '{0, 128, 256};
  int m_abs   [8] = '{0, 0, 0, 64, 0, 0, 0, 0};
  int m_rel   [8] = '{0, 0, -4, 0, 0, 3, 0, 0};
  int ph, m_pc, m_idx, m_cnt;

  typedef struct {
    int pc;
    int run;
    int ack;
    int idx;
    int cnt;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Drive one cycle of inputs and record the outputs expected after the next edge.
  task automatic step(input bit rst, input bit st, input bit halt, input bit abs_en,
                      input bit rel_en, input bit z, input int sel);
    exp_t e;
    @(negedge clk);
    Reset = rst; Start = st; HaltReq = halt; BranchAbsEn = abs_en;
    BranchRelEn = rel_en; AluZero = z; TargSel = 3'(sel);
    if (rst) begin
      ph = P_IDLE; m_pc = 0; m_idx = 0; m_cnt = 0;
    end else begin
      case (ph)
        P_IDLE: if (st) ph = P_ARMED;
        P_ARMED: if (!st) ph = P_RUN;
        P_RUN: begin
          if (st) ph = P_ARMED;
          else begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (halt) ph = P_DONE;
            else if (abs_en) m_pc = m_abs[sel];
            else if (rel_en && z) m_pc = (m_pc + m_rel[sel] + 1024) % 1024;
            else m_pc = (m_pc + 1) % 1024;
          end
        end
        default: if (st) begin
          ph = P_ARMED;
          m_idx = (m_idx + 1) % 3;
        end
      endcase
      if (ph == P_ARMED) begin
        m_pc  = m_entry[m_idx];
        m_cnt = 0;
      end
    end
    e.pc = m_pc; e.run = (ph == P_RUN); e.ack = (ph == P_DONE);
    e.idx = m_idx; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic plain(input bit st);
    step(0, st, 0, 0, 0, 0, 0);
  endtask

  task automatic launch(input int hold);
    for (int i = 0; i < hold; i++) plain(1);
    plain(0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ProgCtr",    32'(ProgCtr),    e.pc);
        chk("Running",    32'(Running),    e.run);
        chk("Ack",        32'(Ack),        e.ack);
        chk("ProgIdx",    32'(ProgIdx),    e.idx);
        chk("CycleCount", 32'(CycleCount), e.cnt);
      end
    end
  end

  initial begin
    int guard;
    Reset = 1; Start = 0; HaltReq = 0; BranchAbsEn = 0; BranchRelEn = 0;
    AluZero = 0; TargSel = 0;
    ph = P_IDLE; m_pc = 0; m_idx = 0; m_cnt = 0;

    // Reset, arm, run from entry 0x000.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    launch(3);
    plain(0); plain(0);

    // Branches at PC 0x010.
    guard = 0;
    while (m_pc != 16 && guard < 100) begin plain(0); guard++; end
    if (guard >= 100) bound_fail("reach_pc_010");
    step(0, 0, 0, 1, 0, 0, 3);   // abs -> 0x040
    step(0, 0, 0, 0, 1, 1, 2);   // rel -4 taken -> 0x03C
    step(0, 0, 0, 0, 1, 0, 2);   // not taken -> 0x03D
    step(0, 0, 0, 1, 1, 1, 5);   // both: absolute wins -> 0x000
    step(0, 0, 1, 0, 0, 0, 0);   // halt
    repeat (3) step(0, 0, 1, 1, 1, 1, 3);  // ignored in DONE

    // Programs 1 and 2, then wrap to program 0.
    for (int p = 0; p < 2; p++) begin
      launch(2);
      repeat (4) plain(0);
      step(0, 0, 1, 0, 0, 0, 0);
    end
    launch(2);
    guard = 0;
    while (m_pc != 5 && guard < 100) begin plain(0); guard++; end
    if (guard >= 100) bound_fail("reach_pc_005");
    step(0, 0, 1, 1, 0, 0, 3);   // halt beats abs jump
    repeat (4) plain(0);

    // Program 1, walk to PC 0x023, then reset mid-run.
    launch(2);
    guard = 0;
    while (m_pc != 35 && guard < 300) begin
      step(0, 0, 0, 0, ((m_pc - 35) % 4) == 0, 1, 2);
      guard++;
    end
    if (guard >= 300) bound_fail("reach_pc_023");
    step(1, 0, 0, 0, 0, 0, 0);
    plain(0);

    // Relative wrap below zero and PC wrap 0x3FF -> 0x000, then abort.
    launch(2);
    plain(0);
    step(0, 0, 0, 0, 1, 1, 2);
    repeat (3) plain(0);
    plain(1);
    plain(1);
    plain(0);
    plain(0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 255) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
